// File: rtl/foc_pkg.sv
// Shared defaults, quarter-period helper and FSM state encoding for the
// field-oriented-control datapath blocks.
package foc_pkg;

  localparam int AW_DEF = 10;
  localparam int DW_DEF = 16;
  localparam int IW_DEF = 16;

  // Table offset turning a sin address into the matching cos address (pi/2).
  function automatic int quarter_offset(input int aw);
    return 32'sd1 <<< (aw - 2);
  endfunction

  localparam int QUARTER_OFFSET = quarter_offset(AW_DEF);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_WAIT = 3'd2,
    ST_M0   = 3'd3,
    ST_M1   = 3'd4,
    ST_M2   = 3'd5,
    ST_M3   = 3'd6,
    ST_OUT  = 3'd7
  } park_state_e;

endpackage

// File: rtl/park_mac.sv
// Combinational multiply-accumulate step: acc_out = (clear ? 0 : acc_in) +/- a*b.
// The accumulator width leaves one guard bit so two full-scale products never overflow.
module park_mac #(
  parameter int IW   = 16,
  parameter int DW   = 16,
  parameter int ACCW = IW + DW + 1
) (
  input  logic signed [IW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  input  logic                   neg,
  input  logic                   clear,
  input  logic signed [ACCW-1:0] acc_in,
  output logic signed [ACCW-1:0] acc_out
);

  logic signed [IW+DW-1:0] prod;
  logic signed [ACCW-1:0]  term;
  logic signed [ACCW-1:0]  base;

  // product, optional negation and clear/accumulate select
  always_comb begin
    prod = a * b;
    if (neg) begin
      term = -ACCW'(prod);
    end else begin
      term = ACCW'(prod);
    end
    if (clear) begin
      base = '0;
    end else begin
      base = acc_in;
    end
    acc_out = base + term;
  end

endmodule

// File: rtl/park_transform.sv
// Park transform (alpha/beta -> d/q) using an external registered sin/cos table
// and a single time-shared multiplier; one result every 8 cycles.
module park_transform
  import foc_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int IW = IW_DEF
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 ready,
  input  logic [AW-1:0]        theta,
  input  logic signed [IW-1:0] i_alpha,
  input  logic signed [IW-1:0] i_beta,
  output logic [AW-1:0]        addr_sin,
  output logic [AW-1:0]        addr_cos,
  input  logic signed [DW-1:0] data_sin,
  input  logic signed [DW-1:0] data_cos,
  output logic signed [IW-1:0] i_d,
  output logic signed [IW-1:0] i_q,
  output logic                 out_valid
);

  localparam int ACCW = IW + DW + 1;
  localparam logic [AW-1:0] QUARTER = AW'(quarter_offset(AW));
  localparam logic signed [ACCW-1:0] MAX_V = {{(ACCW-IW+1){1'b0}}, {(IW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MIN_V = {{(ACCW-IW+1){1'b1}}, {(IW-1){1'b0}}};

  park_state_e             state_r;
  logic signed [IW-1:0]    alpha_r;
  logic signed [IW-1:0]    beta_r;
  logic signed [DW-1:0]    sin_r;
  logic signed [DW-1:0]    cos_r;
  logic signed [ACCW-1:0]  acc_d_r;
  logic signed [ACCW-1:0]  acc_q_r;

  logic signed [IW-1:0]    mac_a_s;
  logic signed [DW-1:0]    mac_b_s;
  logic                    mac_neg_s;
  logic                    mac_clear_s;
  logic signed [ACCW-1:0]  mac_in_s;
  logic signed [ACCW-1:0]  mac_out_s;

  // Floor shift back to the current scale, then clamp to the IW-bit range.
  function automatic logic signed [IW-1:0] shift_sat(input logic signed [ACCW-1:0] acc);
    logic signed [ACCW-1:0] sh;
    sh = acc >>> (DW - 1);
    if (sh > MAX_V) begin
      return MAX_V[IW-1:0];
    end else if (sh < MIN_V) begin
      return MIN_V[IW-1:0];
    end else begin
      return sh[IW-1:0];
    end
  endfunction

  // operand schedule for the shared multiplier
  always_comb begin
    mac_a_s     = alpha_r;
    mac_b_s     = cos_r;
    mac_neg_s   = 1'b0;
    mac_clear_s = 1'b1;
    mac_in_s    = acc_d_r;
    case (state_r)
      ST_M0: begin
        mac_a_s = alpha_r; mac_b_s = cos_r; mac_clear_s = 1'b1; mac_in_s = acc_d_r;
      end
      ST_M1: begin
        mac_a_s = beta_r; mac_b_s = sin_r; mac_clear_s = 1'b0; mac_in_s = acc_d_r;
      end
      ST_M2: begin
        mac_a_s = alpha_r; mac_b_s = sin_r; mac_neg_s = 1'b1; mac_clear_s = 1'b1;
        mac_in_s = acc_q_r;
      end
      ST_M3: begin
        mac_a_s = beta_r; mac_b_s = cos_r; mac_clear_s = 1'b0; mac_in_s = acc_q_r;
      end
      default: begin
        mac_a_s     = alpha_r;
        mac_b_s     = cos_r;
        mac_neg_s   = 1'b0;
        mac_clear_s = 1'b1;
        mac_in_s    = acc_d_r;
      end
    endcase
  end

  park_mac #(.IW(IW), .DW(DW), .ACCW(ACCW)) u_mac (
    .a       (mac_a_s),
    .b       (mac_b_s),
    .neg     (mac_neg_s),
    .clear   (mac_clear_s),
    .acc_in  (mac_in_s),
    .acc_out (mac_out_s)
  );

  // sequencer FSM with all datapath registers and registered outputs
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      ready     <= 1'b1;
      out_valid <= 1'b0;
      i_d       <= '0;
      i_q       <= '0;
      addr_sin  <= '0;
      addr_cos  <= '0;
      alpha_r   <= '0;
      beta_r    <= '0;
      sin_r     <= '0;
      cos_r     <= '0;
      acc_d_r   <= '0;
      acc_q_r   <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            alpha_r  <= i_alpha;
            beta_r   <= i_beta;
            addr_sin <= theta;
            addr_cos <= theta + QUARTER;
            ready    <= 1'b0;
            state_r  <= ST_ADDR;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ADDR: state_r <= ST_WAIT;
        ST_WAIT: begin
          sin_r   <= data_sin;
          cos_r   <= data_cos;
          state_r <= ST_M0;
        end
        ST_M0: begin
          acc_d_r <= mac_out_s;
          state_r <= ST_M1;
        end
        ST_M1: begin
          acc_d_r <= mac_out_s;
          state_r <= ST_M2;
        end
        ST_M2: begin
          acc_q_r <= mac_out_s;
          state_r <= ST_M3;
        end
        ST_M3: begin
          acc_q_r <= mac_out_s;
          state_r <= ST_OUT;
        end
        ST_OUT: begin
          i_d       <= shift_sat(acc_d_r);
          i_q       <= shift_sat(acc_q_r);
          out_valid <= 1'b1;
          ready     <= 1'b1;
          state_r   <= ST_IDLE;
        end
        default: begin
          ready   <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
